// File: rtl/fft_input_framer.sv
// fft_input_framer
// Ping-pong frame buffer in front of the first FFT butterfly stage. Input
// samples are collected into one of two N-word banks (N = 2^N_LOG2). Each
// full bank is then played out on N consecutive cycles, with single-cycle
// start/over pulses on the first and last samples.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   in_valid / in_ready          input handshake (in_ready is combinational)
//   in_real, in_img              input sample, two's complement
//   start, over                  first / last sample of an output frame
//   out_valid                    output sample present
//   data_out_real, data_out_img  output sample (zero when out_valid is low)
//   frames_out                   completed output frames, wraps at 2^16
//
// Read FSM
//   state | meaning
//   IDLE  | waiting for full[rd_bank] and the gap counter to reach 0
//   PLAY  | issuing read addresses rd_addr = 1..N-1 of the current bank
module fft_input_framer #(
    parameter int N_LOG2  = 11,
    parameter int DATA_W  = 32,
    parameter int MIN_GAP = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_real,
    input  logic [DATA_W-1:0] in_img,
    output logic              start,
    output logic              over,
    output logic              out_valid,
    output logic [DATA_W-1:0] data_out_real,
    output logic [DATA_W-1:0] data_out_img,
    output logic [15:0]       frames_out
);

    localparam int N     = 1 << N_LOG2;
    localparam int GAP_W = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;

    typedef enum logic {IDLE, PLAY} state_t;

    // Both banks live in one array; the bank select is the address MSB.
    logic [2*DATA_W-1:0] mem [0:2*N-1];

    logic [1:0]        full;
    logic              wr_bank;
    logic [N_LOG2-1:0] wr_addr;
    logic              rd_bank;
    logic [N_LOG2-1:0] rd_addr;
    logic [N_LOG2-1:0] rd_addr_nxt;
    logic [N_LOG2-1:0] issue_addr;
    logic [GAP_W-1:0]  gap_cnt;
    logic [GAP_W-1:0]  gap_nxt;
    state_t            state;
    state_t            state_nxt;

    logic wr_fire;
    logic wr_last;
    logic issue;
    logic rd_done;
    logic other_ready;

    assign in_ready = ~rst & ~full[wr_bank];
    assign wr_fire  = in_valid & in_ready;
    assign wr_last  = wr_fire & (&wr_addr);

    // The other bank counts as ready if it is full or is being completed by
    // the writer this very cycle; this is what lets MIN_GAP = 0 run
    // back-to-back under sustained 1 sample/cycle input.
    assign other_ready = full[~rd_bank] | (wr_last & (wr_bank != rd_bank));

    // Launch from IDLE issues address 0 in the same cycle, so a frame
    // completed at the end of cycle t is read in cycle t+1.
    always_comb begin
        state_nxt   = state;
        issue       = 1'b0;
        issue_addr  = rd_addr;
        rd_addr_nxt = rd_addr;
        rd_done     = 1'b0;
        gap_nxt     = gap_cnt;
        case (state)
            IDLE: begin
                if (gap_cnt != '0) begin
                    gap_nxt = gap_cnt - GAP_W'(1);
                end else if (full[rd_bank]) begin
                    issue       = 1'b1;
                    issue_addr  = '0;
                    rd_addr_nxt = N_LOG2'(1);
                    state_nxt   = PLAY;
                end
            end
            PLAY: begin
                issue       = 1'b1;
                rd_addr_nxt = rd_addr + N_LOG2'(1);
                if (&rd_addr) begin
                    rd_done = 1'b1;
                    gap_nxt = GAP_W'(MIN_GAP);
                    if ((MIN_GAP == 0) && other_ready) begin
                        state_nxt = PLAY;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[{wr_bank, wr_addr}] <= {in_real, in_img};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            full          <= '0;
            wr_bank       <= 1'b0;
            wr_addr       <= '0;
            rd_bank       <= 1'b0;
            rd_addr       <= '0;
            gap_cnt       <= '0;
            out_valid     <= 1'b0;
            start         <= 1'b0;
            over          <= 1'b0;
            data_out_real <= '0;
            data_out_img  <= '0;
            frames_out    <= '0;
        end else begin
            state   <= state_nxt;
            rd_addr <= rd_addr_nxt;
            gap_cnt <= gap_nxt;

            if (wr_fire) begin
                wr_addr <= wr_addr + N_LOG2'(1);
                if (wr_last) begin
                    full[wr_bank] <= 1'b1;
                    wr_bank       <= ~wr_bank;
                end
            end
            // The writer never targets a full bank, so this clear can never
            // collide with the set above on the same bit.
            if (rd_done) begin
                full[rd_bank] <= 1'b0;
                rd_bank       <= ~rd_bank;
            end

            out_valid <= issue;
            start     <= issue & (issue_addr == '0);
            over      <= issue & (&issue_addr);
            if (issue) begin
                {data_out_real, data_out_img} <= mem[{rd_bank, issue_addr}];
            end else begin
                {data_out_real, data_out_img} <= '0;
            end
            if (issue & (&issue_addr)) begin
                frames_out <= frames_out + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_fft_input_framer.sv
// tb_fft_input_framer
// Directed bench for fft_input_framer. Four instances with different
// parameters share clock, reset and input data; sel routes in_valid to one
// instance and picks which instance's outputs the monitor observes.
//   sel 0: N_LOG2=3,  MIN_GAP=2
//   sel 1: N_LOG2=3,  MIN_GAP=0
//   sel 2: N_LOG2=4,  MIN_GAP=2
//   sel 3: N_LOG2=11, MIN_GAP=2 (defaults)
module tb_fft_input_framer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_real = '0;
    logic [31:0] in_img = '0;
    logic [1:0]  sel = 2'd0;
    int          n_cur = 8;

    logic [3:0]       iv;
    logic [3:0]       ir, st, ov, vl;
    logic [3:0][31:0] dr, di;
    logic [3:0][15:0] fo;

    logic        s_in_ready, s_start, s_over, s_out_valid;
    logic [31:0] s_re, s_im;
    logic [15:0] s_frames;

    int n_chk = 0;
    int n_bad = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign iv = {3'b000, in_valid} << sel;

    always_comb begin
        s_in_ready  = ir[sel];
        s_start     = st[sel];
        s_over      = ov[sel];
        s_out_valid = vl[sel];
        s_re        = dr[sel];
        s_im        = di[sel];
        s_frames    = fo[sel];
    end

    fft_input_framer #(.N_LOG2(3), .DATA_W(32), .MIN_GAP(2)) u_n3g2 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
        .in_real(in_real), .in_img(in_img), .start(st[0]), .over(ov[0]),
        .out_valid(vl[0]), .data_out_real(dr[0]), .data_out_img(di[0]),
        .frames_out(fo[0]));

    fft_input_framer #(.N_LOG2(3), .DATA_W(32), .MIN_GAP(0)) u_n3g0 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
        .in_real(in_real), .in_img(in_img), .start(st[1]), .over(ov[1]),
        .out_valid(vl[1]), .data_out_real(dr[1]), .data_out_img(di[1]),
        .frames_out(fo[1]));

    fft_input_framer #(.N_LOG2(4), .DATA_W(32), .MIN_GAP(2)) u_n4g2 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
        .in_real(in_real), .in_img(in_img), .start(st[2]), .over(ov[2]),
        .out_valid(vl[2]), .data_out_real(dr[2]), .data_out_img(di[2]),
        .frames_out(fo[2]));

    fft_input_framer u_dflt (
        .clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(ir[3]),
        .in_real(in_real), .in_img(in_img), .start(st[3]), .over(ov[3]),
        .out_valid(vl[3]), .data_out_real(dr[3]), .data_out_img(di[3]),
        .frames_out(fo[3]));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Scoreboard: the driver pushes every accepted sample, the monitor pops
    // one per out_valid cycle and checks order, framing and idle zeroing.
    logic [63:0] exp_q[$];
    int m_idx, m_frames, m_idle, m_valid_cnt, m_min_gap, m_max_gap;
    int m_start_cyc, m_over_cyc;
    bit m_seen_over;

    always @(negedge clk) begin
        logic [63:0] e;
        if (rst) begin
            exp_q.delete();
            m_idx       = 0;
            m_frames    = 0;
            m_idle      = 0;
            m_valid_cnt = 0;
            m_min_gap   = 999999;
            m_max_gap   = -1;
            m_start_cyc = 0;
            m_over_cyc  = 0;
            m_seen_over = 1'b0;
        end else if (s_out_valid) begin
            chk("start_flag", 64'(s_start), 64'(m_idx == 0));
            chk("over_flag", 64'(s_over), 64'(m_idx == n_cur - 1));
            if (m_idx == 0) begin
                m_start_cyc = cyc;
                if (m_seen_over) begin
                    if (m_idle < m_min_gap) m_min_gap = m_idle;
                    if (m_idle > m_max_gap) m_max_gap = m_idle;
                end
            end
            if (exp_q.size() == 0) begin
                chk("extra_sample", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("data_re", 64'(s_re), 64'(e[63:32]));
                chk("data_im", 64'(s_im), 64'(e[31:0]));
            end
            if (m_idx == n_cur - 1) begin
                m_idx       = 0;
                m_frames    = m_frames + 1;
                m_seen_over = 1'b1;
                m_over_cyc  = cyc;
            end else begin
                m_idx = m_idx + 1;
            end
            m_idle      = 0;
            m_valid_cnt = m_valid_cnt + 1;
        end else begin
            chk("idle_flags", 64'({s_start, s_over}), 64'd0);
            chk("idle_data", {s_re, s_im}, 64'd0);
            chk("gap_free", 64'(m_idx), 64'd0);
            m_idle = m_idle + 1;
        end
    end

    int acc_cyc;
    int n_stall;

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [31:0] re, input logic [31:0] im);
        int w;
        w        = 0;
        in_valid = 1'b1;
        in_real  = re;
        in_img   = im;
        @(negedge clk);
        while (!s_in_ready && w < 5000) begin
            n_stall++;
            @(negedge clk);
            w++;
        end
        if (!s_in_ready) begin
            chk("ready_timeout", 64'd0, 64'd1);
        end else begin
            exp_q.push_back({re, im});
            acc_cyc = cyc;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int k);
        in_valid = 1'b0;
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_frames(input int target);
        int w;
        w = 0;
        while (m_frames < target && w < 20000) begin
            @(negedge clk);
            w++;
        end
        chk("frames_seen", 64'(m_frames), 64'(target));
        idle(4);
    endtask

    task automatic do_reset(input logic [1:0] s, input int n);
        sel      = s;
        n_cur    = n;
        in_valid = 1'b0;
        rst      = 1'b1;
        n_stall  = 0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 64'(s_in_ready), 64'd0);
        chk("rst_flags", 64'({s_start, s_over, s_out_valid}), 64'd0);
        chk("rst_data", {s_re, s_im}, 64'd0);
        chk("rst_frames", 64'(s_frames), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 64'(s_in_ready), 64'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int w;
        logic [31:0] re, im;

        // Single frame, N=8: k / -k, start at t+2, over at t+9.
        do_reset(2'd0, 8);
        for (int k = 0; k < 8; k++) send(32'(k), 32'(-k));
        wait_frames(1);
        chk("t1_start_lat", 64'(m_start_cyc - acc_cyc), 64'd2);
        chk("t1_over_lat", 64'(m_over_cyc - acc_cyc), 64'd9);
        chk("t1_valid_cnt", 64'(m_valid_cnt), 64'd8);
        chk("t1_frames_out", 64'(s_frames), 64'd1);
        chk("t1_q_empty", 64'(exp_q.size()), 64'd0);

        // Backpressure: 4 frames continuous, N=8, MIN_GAP=2.
        do_reset(2'd0, 8);
        for (int k = 0; k < 32; k++) send(32'(k * 3 + 1), 32'(~k));
        wait_frames(4);
        chk("t3_stalled", 64'(n_stall > 0), 64'd1);
        chk("t3_min_gap", 64'(m_min_gap), 64'd2);
        chk("t3_max_gap", 64'(m_max_gap), 64'd2);
        chk("t3_frames_out", 64'(s_frames), 64'd4);
        chk("t3_q_empty", 64'(exp_q.size()), 64'd0);

        // Reset while output sample 5 of a frame is on the bus.
        for (int k = 0; k < 8; k++) send(32'(k), 32'(k + 50));
        w = 0;
        @(negedge clk);
        while (!(s_out_valid && s_re == 32'd5) && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("t5_reach_s5", 64'(s_re), 64'd5);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_flags_rst", 64'({s_start, s_over, s_out_valid}), 64'd0);
        chk("t5_frames_rst", 64'(s_frames), 64'd0);
        chk("t5_data_rst", {s_re, s_im}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 8; k++) send(32'(100 + k), 32'(200 - k));
        wait_frames(1);
        chk("t5_frames_out", 64'(s_frames), 64'd1);
        chk("t5_q_empty", 64'(exp_q.size()), 64'd0);

        // Bursty input, N=16, 3 frames, random idle gaps.
        do_reset(2'd2, 16);
        for (int k = 0; k < 48; k++) begin
            re = $urandom;
            im = $urandom;
            send(re, im);
            idle($urandom_range(0, 3));
        end
        wait_frames(3);
        chk("t2_min_gap_ok", 64'(m_min_gap >= 2), 64'd1);
        chk("t2_valid_cnt", 64'(m_valid_cnt), 64'd48);
        chk("t2_frames_out", 64'(s_frames), 64'd3);
        chk("t2_q_empty", 64'(exp_q.size()), 64'd0);

        // MIN_GAP=0, continuous: frames run back-to-back, no stalls.
        do_reset(2'd1, 8);
        for (int k = 0; k < 24; k++) send(32'(k + 7), 32'(k * 5));
        wait_frames(3);
        chk("t4_min_gap", 64'(m_min_gap), 64'd0);
        chk("t4_max_gap", 64'(m_max_gap), 64'd0);
        chk("t4_no_stall", 64'(n_stall), 64'd0);
        chk("t4_frames_out", 64'(s_frames), 64'd3);

        // Default N=2048, full-scale values.
        do_reset(2'd3, 2048);
        for (int k = 0; k < 2048; k++) begin
            case (k % 4)
                0: begin re = 32'h7FFF_FFFF; im = 32'h8000_0001; end
                1: begin re = 32'h8000_0001; im = 32'h7FFF_FFFF; end
                2: begin re = 32'(k);        im = 32'(-k);       end
                default: begin re = 32'h7FFF_FFFF; im = 32'h7FFF_FFFF; end
            endcase
            send(re, im);
        end
        wait_frames(1);
        chk("t6_start_over", 64'(m_over_cyc - m_start_cyc), 64'd2047);
        chk("t6_valid_cnt", 64'(m_valid_cnt), 64'd2048);
        chk("t6_frames_out", 64'(s_frames), 64'd1);
        chk("t6_q_empty", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
